// File: rtl/lsu_exec.sv
// Load/store execution unit: takes uops from issue, runs them on a req/gnt/rvalid data bus,
// returns load results to writeback/forwarding and reports misaligned and bus-timeout exceptions.
package lsu_exec_pkg;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] imm;
    } uop_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
endpackage

module lsu_exec
    import lsu_exec_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    input  uop_t        i_uop,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_addr_base,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_fwd_valid,
    output logic [4:0]  o_fwd_rd,
    output logic [31:0] o_fwd_data,
    output logic        o_exc_valid,
    output logic [1:0]  o_exc_cause,
    output logic [31:0] o_exc_pc,
    output logic [31:0] o_exc_addr
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    localparam int            CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          is_load_q, killed_q;
    logic [2:0]    f3_q;
    logic [4:0]    rd_q;
    logic [31:0]   pc_q, ea_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic          wb_valid_q, exc_valid_q;
    logic [4:0]    wb_rd_q;
    logic [31:0]   wb_data_q, exc_pc_q, exc_addr_q;
    logic [1:0]    exc_cause_q;

    logic [31:0] ea, wdata_new, shifted, load_val;
    logic [3:0]  be_new;
    logic        dec_load, dec_store, misaligned, accept, go_req;
    logic        load_done, timeout, killed_now;

    // Decode of the offered uop
    always_comb begin
        ea         = i_addr_base + i_uop.imm;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        be_new     = 4'hF;
        wdata_new  = i_store_data;
        if (i_uop.opcode == OPC_LOAD) begin
            case (i_uop.funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_load = 1'b1;
                default:                                dec_load = 1'b0;
            endcase
        end
        if (i_uop.opcode == OPC_STORE) begin
            dec_store = (i_uop.funct3 == 3'b000) || (i_uop.funct3 == 3'b001) || (i_uop.funct3 == 3'b010);
        end
        misaligned = ((i_uop.funct3[1:0] == 2'b01) && ea[0]) ||
                     ((i_uop.funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        if (dec_store) begin
            case (i_uop.funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << ea[1:0];
                    wdata_new = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << ea[1:0];
                    wdata_new = {2{i_store_data[15:0]}};
                end
                default: begin
                    be_new    = 4'hF;
                    wdata_new = i_store_data;
                end
            endcase
        end
        accept = (state_q == ST_IDLE) && i_valid && !i_flush && (dec_load || dec_store);
        go_req = accept && !misaligned;
    end

    // Bus-side events and load extraction
    always_comb begin
        killed_now = killed_q || i_flush;
        load_done  = ((state_q == ST_REQ) && i_dmem_gnt && is_load_q && i_dmem_rvalid) ||
                     ((state_q == ST_WAIT) && i_dmem_rvalid);
        timeout    = (cnt_q == CNT_LAST) &&
                     (((state_q == ST_REQ) && !i_dmem_gnt && !i_flush) ||
                      ((state_q == ST_WAIT) && !i_dmem_rvalid));
        shifted    = i_dmem_rdata >> {ea_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_dmem_gnt) begin
                    state_d = (is_load_q && !i_dmem_rvalid) ? ST_WAIT : ST_IDLE;
                end else if (i_flush || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_dmem_rvalid || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_stall    = (state_q != ST_IDLE);
        o_dmem_req = (state_q == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            killed_q    <= 1'b0;
            f3_q        <= 3'b000;
            rd_q        <= 5'd0;
            pc_q        <= 32'h0;
            ea_q        <= 32'h0;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'b00;
            exc_pc_q    <= 32'h0;
            exc_addr_q  <= 32'h0;
        end else begin
            wb_valid_q <= load_done && !killed_now;
            if (load_done && !killed_now) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_val;
            end
            exc_valid_q <= 1'b0;
            if (accept && misaligned) begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= dec_store ? 2'b10 : 2'b01;
                exc_pc_q    <= i_pc;
                exc_addr_q  <= ea;
            end else if (timeout && !killed_now) begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= 2'b11;
                exc_pc_q    <= pc_q;
                exc_addr_q  <= ea_q;
            end
            if (go_req) begin
                is_load_q <= dec_load;
                killed_q  <= 1'b0;
                f3_q      <= i_uop.funct3;
                rd_q      <= i_uop.rd;
                pc_q      <= i_pc;
                ea_q      <= ea;
                we_q      <= dec_store;
                be_q      <= be_new;
                wdata_q   <= wdata_new;
            end else if ((state_q != ST_IDLE) && i_flush) begin
                killed_q <= 1'b1;
            end
            // Counter restarts on entry to REQ and on the REQ->WAIT hop
            if (go_req || ((state_q == ST_REQ) && (state_d == ST_WAIT))) begin
                cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = {ea_q[31:2], 2'b00};
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_rd      = wb_rd_q;
    assign o_wb_data    = wb_data_q;
    assign o_fwd_valid  = wb_valid_q && (wb_rd_q != 5'd0);
    assign o_fwd_rd     = wb_rd_q;
    assign o_fwd_data   = wb_data_q;
    assign o_exc_valid  = exc_valid_q && !i_flush;
    assign o_exc_cause  = exc_cause_q;
    assign o_exc_pc     = exc_pc_q;
    assign o_exc_addr   = exc_addr_q;
endmodule

// File: tb/tb_lsu_exec.sv
// Randomised bench for lsu_exec: each uop is played cycle by cycle against a transaction-level
// model of access size, byte lanes, extension, latency, flush and timeout rules.
module tb_lsu_exec;
    import lsu_exec_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    uop_t        i_uop = '0;
    logic [31:0] i_pc = 32'h0;
    logic [31:0] i_addr_base = 32'h0;
    logic [31:0] i_store_data = 32'h0;
    logic        i_dmem_gnt = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_stall, o_dmem_req, o_dmem_we, o_wb_valid, o_fwd_valid, o_exc_valid;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data, o_fwd_data, o_exc_pc, o_exc_addr;
    logic [3:0]  o_dmem_be;
    logic [4:0]  o_wb_rd, o_fwd_rd;
    logic [1:0]  o_exc_cause;

    int n_checks = 0;
    int n_errors = 0;

    lsu_exec #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .i_uop(i_uop),
        .i_pc(i_pc), .i_addr_base(i_addr_base), .i_store_data(i_store_data),
        .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data),
        .o_exc_valid(o_exc_valid), .o_exc_cause(o_exc_cause), .o_exc_pc(o_exc_pc),
        .o_exc_addr(o_exc_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference rules expressed as plain arithmetic on access size
    function automatic int ref_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] ea);
        return (ea % ref_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f3, input logic [31:0] ea);
        int mask;
        if (!st) return 4'hF;
        mask = ((1 << ref_size(f3)) - 1) << (ea % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (ref_size(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (ref_size(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rdata);
        logic [31:0] w, mask;
        int sz;
        sz = ref_size(f3);
        w = rdata >> (8 * (ea % 4));
        if (sz == 4) return w;
        mask = (32'h1 << (8 * sz)) - 1;
        w = w & mask;
        if (!f3[2] && ((w >> (8 * sz - 1)) & 1) != 0) w = w | ~mask;
        return w;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata = $urandom;
    endtask

    task automatic offer(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] base, input logic [31:0] imm, input logic [31:0] data,
                         input logic [31:0] pc);
        i_valid = 1'b1;
        i_uop.opcode = st ? OPC_STORE : OPC_LOAD;
        i_uop.funct3 = f3;
        i_uop.rd = rd;
        i_uop.imm = imm;
        i_pc = pc;
        i_addr_base = base;
        i_store_data = data;
    endtask

    // flush_mode: 0 none, 1 flush at REQ cycle flush_k, 2 flush at WAIT cycle flush_k
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] base, input logic [31:0] imm, input logic [31:0] data,
                          input logic [31:0] rdata, input int gnt_lat, input int rv_lat,
                          input int flush_mode, input int flush_k);
        logic [31:0] ea, pc;
        bit killed, granted, withdrawn, got_rv;
        ea = base + imm;
        pc = $urandom & 32'hFFFF_FFFC;
        $display("op %s f3=%0d rd=%0d ea=%08h gnt_lat=%0d rv_lat=%0d flush=%0d/%0d",
                 st ? "ST" : "LD", f3, rd, ea, gnt_lat, rv_lat, flush_mode, flush_k);
        next_cycle();
        offer(st, f3, rd, base, imm, data, pc);
        #1 check("stall_idle", o_stall, 1'b0);
        next_cycle();
        #1;
        if (ref_misaligned(f3, ea)) begin
            check("mis_exc_valid", o_exc_valid, 1'b1);
            check("mis_exc_cause", o_exc_cause, st ? 2'b10 : 2'b01);
            check("mis_exc_addr", o_exc_addr, ea);
            check("mis_exc_pc", o_exc_pc, pc);
            check("mis_no_req", o_dmem_req, 1'b0);
            check("mis_no_stall", o_stall, 1'b0);
            return;
        end
        killed = 0; granted = 0; withdrawn = 0;
        for (int k = 0; k < TO; k++) begin
            if (k > 0) next_cycle();
            i_dmem_gnt = (k == gnt_lat);
            i_flush = (flush_mode == 1 && k == flush_k);
            i_dmem_rvalid = (k == gnt_lat && !st && rv_lat == 0);
            i_dmem_rdata = rdata;
            #1;
            check("req", o_dmem_req, 1'b1);
            check("stall_req", o_stall, 1'b1);
            check("addr", o_dmem_addr, ea & 32'hFFFF_FFFC);
            check("we", o_dmem_we, st);
            check("be", o_dmem_be, ref_be(st, f3, ea));
            if (st) check("wdata", o_dmem_wdata, ref_wdata(f3, data));
            if (i_flush && !i_dmem_gnt) begin withdrawn = 1; break; end
            if (i_dmem_gnt) begin granted = 1; killed = i_flush; break; end
        end
        if (withdrawn) begin
            next_cycle(); #1;
            check("wd_req", o_dmem_req, 1'b0);
            check("wd_stall", o_stall, 1'b0);
            check("wd_exc", o_exc_valid, 1'b0);
        end else if (!granted) begin
            next_cycle(); #1;
            check("to_exc_valid", o_exc_valid, 1'b1);
            check("to_exc_cause", o_exc_cause, 2'b11);
            check("to_exc_pc", o_exc_pc, pc);
            check("to_exc_addr", o_exc_addr, ea);
            check("to_stall", o_stall, 1'b0);
            check("to_req", o_dmem_req, 1'b0);
            i_dmem_rvalid = 1'b1;
            next_cycle(); #1;
            check("to_stray_wb", o_wb_valid, 1'b0);
        end else if (st) begin
            next_cycle(); #1;
            check("st_stall", o_stall, 1'b0);
            check("st_no_wb", o_wb_valid, 1'b0);
            check("st_no_exc", o_exc_valid, 1'b0);
        end else begin
            got_rv = (rv_lat == 0);
            if (!got_rv) begin
                for (int k = 0; k < TO; k++) begin
                    next_cycle();
                    i_dmem_rvalid = (k == rv_lat - 1);
                    i_dmem_rdata = rdata;
                    i_flush = (flush_mode == 2 && k == flush_k);
                    if (i_flush) killed = 1;
                    #1;
                    check("wait_stall", o_stall, 1'b1);
                    check("wait_req", o_dmem_req, 1'b0);
                    check("wait_wb", o_wb_valid, 1'b0);
                    if (i_dmem_rvalid) begin got_rv = 1; break; end
                end
            end
            next_cycle(); #1;
            check("ld_stall_done", o_stall, 1'b0);
            check("wb_valid", o_wb_valid, got_rv && !killed);
            if (got_rv && !killed) begin
                check("wb_rd", o_wb_rd, rd);
                check("wb_data", o_wb_data, ref_load(f3, ea, rdata));
                check("fwd_valid", o_fwd_valid, rd != 0);
                check("fwd_data", o_fwd_data, ref_load(f3, ea, rdata));
            end
            check("ld_exc_valid", o_exc_valid, !got_rv && !killed);
            if (!got_rv && !killed) check("ld_exc_cause", o_exc_cause, 2'b11);
            if (!got_rv) begin
                i_dmem_rvalid = 1'b1;
                next_cycle(); #1;
                check("ld_stray_wb", o_wb_valid, 1'b0);
            end
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", o_stall, 1'b0);
        check("rst_req", o_dmem_req, 1'b0);
        check("rst_wb", o_wb_valid, 1'b0);
        check("rst_exc", o_exc_valid, 1'b0);
        check("rst_addr", o_dmem_addr, 32'h0);
        check("rst_be", o_dmem_be, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the functional description
        run_op(0, 3'b010, 5'd5, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0);
        run_op(0, 3'b000, 5'd6, 32'h100, 32'h3, 32'h0, 32'h80FF_FFFF, 0, 1, 0, 0);
        run_op(0, 3'b100, 5'd7, 32'h100, 32'h3, 32'h0, 32'h80FF_FFFF, 1, 0, 0, 0);
        run_op(0, 3'b101, 5'd8, 32'h102, 32'h0, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 0);
        run_op(1, 3'b000, 5'd0, 32'h200, 32'h1, 32'h12345678, 32'h0, 1, 0, 0, 0);
        run_op(0, 3'b010, 5'd3, 32'h100, 32'h2, 32'h0, 32'h0, 0, 0, 0, 0);
        run_op(1, 3'b001, 5'd0, 32'h0, 32'h1, 32'h0, 32'h0, 0, 0, 0, 0);
        run_op(0, 3'b010, 5'd9, 32'h300, 32'h0, 32'h0, 32'h0, TO, 0, 0, 0);
        run_op(0, 3'b010, 5'd9, 32'h300, 32'h0, 32'h0, 32'h1234, 0, 3, 2, 0);
        run_op(1, 3'b010, 5'd0, 32'h300, 32'h0, 32'h55, 32'h0, 2, 0, 1, 0);
        run_op(0, 3'b010, 5'd0, 32'h400, 32'h4, 32'h0, 32'hCAFE_F00D, TO - 1, TO, 0, 0);
        run_op(0, 3'b001, 5'd4, 32'h400, 32'h0, 32'h0, 32'h0, 0, TO + 1, 0, 0);

        // Flush in IDLE and an unsupported funct3 must both leave the unit idle
        next_cycle();
        offer(0, 3'b010, 5'd1, 32'h500, 32'h0, 32'h0, 32'h0);
        i_flush = 1'b1;
        next_cycle(); #1;
        check("idle_flush_req", o_dmem_req, 1'b0);
        check("idle_flush_stall", o_stall, 1'b0);
        offer(0, 3'b011, 5'd1, 32'h500, 32'h0, 32'h0, 32'h0);
        next_cycle(); #1;
        check("bad_f3_req", o_dmem_req, 1'b0);
        check("bad_f3_exc", o_exc_valid, 1'b0);

        // Asynchronous reset in the middle of an access
        offer(0, 3'b010, 5'd2, 32'h600, 32'h0, 32'h0, 32'h0);
        next_cycle(); #1;
        check("ar_req_before", o_dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req_drop", o_dmem_req, 1'b0);
        check("ar_stall_drop", o_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        i_dmem_rvalid = 1'b1;
        next_cycle(); #1;
        check("ar_no_wb", o_wb_valid, 1'b0);

        for (int n = 0; n < 150; n++) begin
            bit st;
            logic [2:0] f3;
            logic [31:0] ea, imm;
            int gl, rl, fm, fk, r;
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            ea = $urandom;
            if ($urandom_range(0, 9) < 7) ea = ea & ~(ref_size(f3) - 1);
            imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            r = $urandom_range(0, 9);
            gl = (r < 7) ? $urandom_range(0, 3) : (r < 9) ? TO - 1 : TO;
            r = $urandom_range(0, 9);
            rl = (r < 7) ? $urandom_range(0, 3) : (r < 9) ? TO : TO + 1;
            fm = 0; fk = 0;
            r = $urandom_range(0, 7);
            if (r == 0) begin
                fm = 1;
                fk = $urandom_range(0, (gl < TO) ? gl : TO - 1);
            end else if (r == 1 && !st && rl > 0 && gl < TO) begin
                fm = 2;
                fk = $urandom_range(0, (rl - 1 < TO - 1) ? rl - 1 : TO - 1);
            end
            run_op(st, f3, 5'($urandom_range(0, 31)), ea - imm, imm, $urandom, $urandom, gl, rl, fm, fk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
